// File: rtl/bfu_pkg.sv
// Shared types, constants and the modular-halving helper for the NTT/INTT butterfly pipeline.
package bfu_pkg;

  localparam int unsigned BFU_DW = 32;
  localparam int unsigned BFU_TW = 8;
  localparam logic [BFU_DW-1:0] BFU_Q_DEFAULT = 32'd8380417;

  typedef enum logic {
    BFU_NTT  = 1'b0,
    BFU_INTT = 1'b1
  } bfu_mode_e;

  // wp holds the twiddle in S1 and the full-width product in S2
  typedef struct packed {
    logic               valid;
    bfu_mode_e          mode;
    logic [BFU_TW-1:0]  tag;
    logic [BFU_DW-1:0]  a;
    logic [BFU_DW-1:0]  bd;
    logic [2*BFU_DW-1:0] wp;
  } bfu_stage_t;

  // Exact multiplication by 2^-1 mod q: odd values are lifted by q before shifting
  function automatic logic [BFU_DW-1:0] mod_half(input logic [BFU_DW-1:0] x,
                                                 input logic [BFU_DW-1:0] q);
    logic [BFU_DW:0] s;
    if (x[0]) begin
      s = {1'b0, x} + {1'b0, q};
    end else begin
      s = {1'b0, x};
    end
    return BFU_DW'(s >> 1);
  endfunction

endpackage

// File: rtl/mod_reduce.sv
// Combinational reduction of a double-width product modulo Val_Q.
module mod_reduce #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned Val_Q      = 8380417
) (
  input  logic [2*DATA_WIDTH-1:0] value,
  output logic [DATA_WIDTH-1:0]   result
);

  localparam logic [2*DATA_WIDTH-1:0] Q_2W = (2*DATA_WIDTH)'(Val_Q);

  assign result = DATA_WIDTH'(value % Q_2W);

endmodule

// File: rtl/ntt_intt_bfu_pipe.sv
// Three-stage unified CT (NTT) / GS-with-halving (INTT) modular butterfly with
// valid/ready handshake, global stall and a pass-through sideband tag.
module ntt_intt_bfu_pipe
  import bfu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned Val_Q      = 8380417,
  parameter int unsigned TAG_WIDTH  = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  mode_i,
  input  logic [DATA_WIDTH-1:0] data1_i,
  input  logic [DATA_WIDTH-1:0] data2_i,
  input  logic [DATA_WIDTH-1:0] w_i,
  input  logic [TAG_WIDTH-1:0]  tag_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] data1_o,
  output logic [DATA_WIDTH-1:0] data2_o,
  output logic [TAG_WIDTH-1:0]  tag_o,
  output logic                  mode_o,
  output logic                  range_err_o
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam logic [DW-1:0]   Q_W  = DW'(Val_Q);
  localparam logic [2*DW-1:0] Q_2W = (2*DW)'(Val_Q);

  logic            stall_s;
  logic            accept_s;
  logic [DW-1:0]   a_red_s, b_red_s, w_red_s;
  logic [2*DW-1:0] sum_s, diff_s, add_s, sub_s;
  logic [DW-1:0]   t_s, res1_s, res2_s;
  bfu_stage_t      s1_d_s, s1_r, s2_d_s, s2_r;
  logic            out_valid_r, mode_r, range_err_r;
  logic [DW-1:0]   data1_r, data2_r;
  logic [TAG_WIDTH-1:0] tag_r;
  logic            unused_bd_s;

  assign stall_s    = out_valid_r & ~out_ready_i;
  assign in_ready_o = ~stall_s;
  assign accept_s   = in_valid_i & ~stall_s;

  // Out-of-range operands are folded back into [0, Q-1] before any use
  assign a_red_s = data1_i % Q_W;
  assign b_red_s = data2_i % Q_W;
  assign w_red_s = w_i % Q_W;

  // S1 next state: operand capture, INTT sum/difference
  always_comb begin
    s1_d_s = s1_r;
    sum_s  = {{DW{1'b0}}, a_red_s} + {{DW{1'b0}}, b_red_s};
    diff_s = {{DW{1'b0}}, a_red_s} + Q_2W - {{DW{1'b0}}, b_red_s};
    if (sum_s >= Q_2W) begin
      sum_s = sum_s - Q_2W;
    end else begin
      sum_s = sum_s;
    end
    if (diff_s >= Q_2W) begin
      diff_s = diff_s - Q_2W;
    end else begin
      diff_s = diff_s;
    end
    s1_d_s.valid = in_valid_i;
    if (in_valid_i) begin
      s1_d_s.mode = bfu_mode_e'(mode_i);
      s1_d_s.tag  = tag_i;
      s1_d_s.wp   = {{DW{1'b0}}, w_red_s};
      case (bfu_mode_e'(mode_i))
        BFU_NTT: begin
          s1_d_s.a  = a_red_s;
          s1_d_s.bd = b_red_s;
        end
        BFU_INTT: begin
          s1_d_s.a  = DW'(sum_s);
          s1_d_s.bd = DW'(diff_s);
        end
        default: begin
          s1_d_s.a  = a_red_s;
          s1_d_s.bd = b_red_s;
        end
      endcase
    end else begin
      s1_d_s.valid = 1'b0;
    end
  end

  // S2 next state: full-width product of b (or d) and the twiddle
  always_comb begin
    s2_d_s       = s2_r;
    s2_d_s.valid = s1_r.valid;
    if (s1_r.valid) begin
      s2_d_s.mode = s1_r.mode;
      s2_d_s.tag  = s1_r.tag;
      s2_d_s.a    = s1_r.a;
      s2_d_s.bd   = s1_r.bd;
      s2_d_s.wp   = {{DW{1'b0}}, s1_r.bd} * s1_r.wp;
    end else begin
      s2_d_s.valid = 1'b0;
    end
  end

  mod_reduce #(
    .DATA_WIDTH(DATA_WIDTH),
    .Val_Q     (Val_Q)
  ) u_mod_reduce (
    .value (s2_r.wp),
    .result(t_s)
  );

  // The raw difference is only needed until the product exists
  assign unused_bd_s = ^s2_r.bd;

  // S3 combinational: final add/sub (NTT) or halving (INTT)
  always_comb begin
    add_s = {{DW{1'b0}}, s2_r.a} + {{DW{1'b0}}, t_s};
    sub_s = {{DW{1'b0}}, s2_r.a} + Q_2W - {{DW{1'b0}}, t_s};
    if (add_s >= Q_2W) begin
      add_s = add_s - Q_2W;
    end else begin
      add_s = add_s;
    end
    if (sub_s >= Q_2W) begin
      sub_s = sub_s - Q_2W;
    end else begin
      sub_s = sub_s;
    end
    case (s2_r.mode)
      BFU_NTT: begin
        res1_s = DW'(add_s);
        res2_s = DW'(sub_s);
      end
      BFU_INTT: begin
        res1_s = mod_half(s2_r.a, Q_W);
        res2_s = mod_half(t_s, Q_W);
      end
      default: begin
        res1_s = DW'(add_s);
        res2_s = DW'(sub_s);
      end
    endcase
  end

  // Pipeline and output registers, all held together while the output is stalled
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_r        <= {$bits(bfu_stage_t){1'b0}};
      s2_r        <= {$bits(bfu_stage_t){1'b0}};
      out_valid_r <= 1'b0;
      data1_r     <= {DW{1'b0}};
      data2_r     <= {DW{1'b0}};
      tag_r       <= {TAG_WIDTH{1'b0}};
      mode_r      <= 1'b0;
    end else if (!stall_s) begin
      s1_r        <= s1_d_s;
      s2_r        <= s2_d_s;
      out_valid_r <= s2_r.valid;
      if (s2_r.valid) begin
        data1_r <= res1_s;
        data2_r <= res2_s;
        tag_r   <= s2_r.tag;
        mode_r  <= s2_r.mode;
      end else begin
        data1_r <= data1_r;
        data2_r <= data2_r;
        tag_r   <= tag_r;
        mode_r  <= mode_r;
      end
    end else begin
      s1_r        <= s1_r;
      s2_r        <= s2_r;
      out_valid_r <= out_valid_r;
    end
  end

  // Sticky flag for any accepted operand at or above Q
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      range_err_r <= 1'b0;
    end else if (accept_s && ((data1_i >= Q_W) || (data2_i >= Q_W) || (w_i >= Q_W))) begin
      range_err_r <= 1'b1;
    end else begin
      range_err_r <= range_err_r;
    end
  end

  assign out_valid_o = out_valid_r;
  assign data1_o     = data1_r;
  assign data2_o     = data2_r;
  assign tag_o       = tag_r;
  assign mode_o      = mode_r;
  assign range_err_o = range_err_r;

endmodule

// File: tb/tb_ntt_intt_bfu_pipe.sv
// Scoreboard bench for ntt_intt_bfu_pipe: directed vectors with hand-computed results.
module tb_ntt_intt_bfu_pipe;

  logic        clk = 1'b0;
  logic        reset_i, in_valid_i, in_ready_o, mode_i;
  logic [31:0] data1_i, data2_i, w_i, data1_o, data2_o;
  logic [7:0]  tag_i, tag_o;
  logic        out_valid_o, out_ready_i, mode_o, range_err_o;

  ntt_intt_bfu_pipe dut (
    .clk_i(clk), .reset_i(reset_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .mode_i(mode_i), .data1_i(data1_i), .data2_i(data2_i), .w_i(w_i), .tag_i(tag_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .data1_o(data1_o),
    .data2_o(data2_o), .tag_o(tag_o), .mode_o(mode_o), .range_err_o(range_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          mode;
    logic [31:0] a, b, w, e1, e2;
  } vec_t;

  typedef struct {
    logic [31:0] e1, e2;
    logic [7:0]  tag;
    bit          mode;
  } exp_t;

  // Expected values worked out by hand with Q = 8380417
  vec_t tbl [0:12] = '{
    '{1'b0, 32'd1,       32'd2,       32'd3,       32'd7,       32'd8380412},
    '{1'b1, 32'd7,       32'd8380412, 32'd1,       32'd1,       32'd6},
    '{1'b1, 32'd1,       32'd0,       32'd1,       32'd4190209, 32'd4190209},
    '{1'b0, 32'd8380416, 32'd8380416, 32'd8380416, 32'd0,       32'd8380415},
    '{1'b0, 32'd8380417, 32'd8380416, 32'd8380416, 32'd1,       32'd8380416},
    '{1'b0, 32'd10,      32'd20,      32'd30,      32'd610,     32'd8379827},
    '{1'b1, 32'd10,      32'd20,      32'd2,       32'd15,      32'd8380407},
    '{1'b0, 32'd0,       32'd1,       32'd1,       32'd1,       32'd8380416},
    '{1'b1, 32'd100,     32'd50,      32'd4,       32'd75,      32'd100},
    '{1'b0, 32'd5,       32'd8380416, 32'd2,       32'd3,       32'd7},
    '{1'b1, 32'd3,       32'd0,       32'd5,       32'd4190210, 32'd4190216},
    '{1'b0, 32'd1000,    32'd1000,    32'd1000,    32'd1001000, 32'd7381417},
    '{1'b1, 32'd8380416, 32'd8380416, 32'd8380416, 32'd8380416, 32'd0}
  };

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic issue(input int idx, input logic [7:0] tag);
    int g;
    mode_i = tbl[idx].mode; data1_i = tbl[idx].a; data2_i = tbl[idx].b;
    w_i = tbl[idx].w; tag_i = tag; in_valid_i = 1'b1;
    g = 0;
    @(negedge clk);
    while (!in_ready_o && g < 100) begin
      g++;
      @(negedge clk);
    end
    if (g >= 100) begin
      n_vec++; n_err++;
      $display("FAIL issue_timeout: tag %0d never accepted", tag);
    end
    @(posedge clk);
    sb.push_back('{tbl[idx].e1, tbl[idx].e2, tag, tbl[idx].mode});
    #1 in_valid_i = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 200) begin
      g++;
      @(posedge clk);
    end
    if (sb.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: %0d results missing", sb.size());
    end
    #1;
  endtask

  // Monitor: pops on every transfer, checks stall behaviour
  bit          prev_stall = 1'b0;
  logic [31:0] prev_d1, prev_d2;
  logic [7:0]  prev_tag;
  always @(negedge clk) begin
    exp_t e;
    if (reset_i) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", out_valid_o, 1);
        chk("hold_data1", data1_o, prev_d1);
        chk("hold_data2", data2_o, prev_d2);
        chk("hold_tag", tag_o, prev_tag);
      end
      if (out_valid_o && !out_ready_i) chk("stall_in_ready", in_ready_o, 0);
      if (out_valid_o && out_ready_i) begin
        if (sb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_out: tag %0d data1 %0d", tag_o, data1_o);
        end else begin
          e = sb.pop_front();
          chk("tag", tag_o, e.tag);
          chk("mode", mode_o, e.mode);
          chk("data1", data1_o, e.e1);
          chk("data2", data2_o, e.e2);
        end
      end
      prev_stall = out_valid_o && !out_ready_i;
      prev_d1 = data1_o; prev_d2 = data2_o; prev_tag = tag_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1; in_valid_i = 1'b0; mode_i = 1'b0; data1_i = 32'd0; data2_i = 32'd0;
    w_i = 32'd0; tag_i = 8'd0; out_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_i = 1'b0;
    chk("rst_valid", out_valid_o, 0);
    chk("rst_data1", data1_o, 0);
    chk("rst_data2", data2_o, 0);
    chk("rst_tag", tag_o, 0);
    chk("rst_mode", mode_o, 0);
    chk("rst_range_err", range_err_o, 0);
    chk("rst_in_ready", in_ready_o, 1);

    // NTT basic with latency check
    issue(0, 8'h11);
    chk("lat_edge1", out_valid_o, 0);
    @(posedge clk); #1 chk("lat_edge2", out_valid_o, 0);
    @(posedge clk); #1 chk("lat_edge3", out_valid_o, 1);
    drain();

    // INTT, including odd halving
    issue(1, 8'h12);
    issue(2, 8'h13);
    drain();

    // Wrap-around at Q-1, then an out-of-range operand
    issue(3, 8'h14);
    drain();
    chk("range_err_clear", range_err_o, 0);
    issue(4, 8'h15);
    chk("range_err_set", range_err_o, 1);
    drain();
    chk("range_err_sticky", range_err_o, 1);

    // Back-to-back mixed stream
    for (int i = 5; i <= 12; i++) issue(i, 8'(i - 5));
    drain();

    // Same stream with a 4-cycle downstream stall mid-way
    fork
      begin
        for (int i = 5; i <= 12; i++) issue(i, 8'(8'h20 + i));
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready_i = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready_i = 1'b1;
      end
    join
    drain();
    chk("range_err_sticky2", range_err_o, 1);

    // Reset with three transactions in flight
    out_ready_i = 1'b0;
    issue(0, 8'h30);
    issue(1, 8'h31);
    issue(2, 8'h32);
    reset_i = 1'b1;
    @(posedge clk);
    #1 reset_i = 1'b0;
    sb.delete();
    chk("mid_rst_valid", out_valid_o, 0);
    chk("mid_rst_data1", data1_o, 0);
    chk("mid_rst_data2", data2_o, 0);
    chk("mid_rst_tag", tag_o, 0);
    chk("mid_rst_range_err", range_err_o, 0);
    chk("mid_rst_in_ready", in_ready_o, 1);
    out_ready_i = 1'b1;
    issue(1, 8'h40);
    drain();
    repeat (5) @(posedge clk);
    #1 chk("idle_after_drain", out_valid_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
